// File: rtl/rv2t_fetch_align_expand.sv
// Fetch aligner: splits fetched words into halfword parcels and issues one instruction per cycle.
// Define RV2T_COMPRESSED_EXPAND_EN to compile in RV32C expansion; otherwise 16-bit parcels issue as illegal.
module rv2t_fetch_align_expand #(
  parameter int unsigned BUF_PARCELS = 4,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_data_i,
  output logic                  fetch_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_instr_o,
  output logic [ADDR_WIDTH-1:0] out_pc_o,
  output logic                  out_is_compressed_o,
  output logic                  out_illegal_o
);

  localparam int unsigned PW = $clog2(BUF_PARCELS);
  localparam int unsigned CW = $clog2(BUF_PARCELS + 1);
  localparam logic [PW:0] DEPTH = (PW + 1)'(BUF_PARCELS);
  localparam logic [CW-1:0] MAX_FILL = CW'(BUF_PARCELS - 2);
  localparam logic [0:0] ST_ALIGNED = 1'b0;
  localparam logic [0:0] ST_SKIP_LO = 1'b1;

  logic [15:0]           fifo_q [BUF_PARCELS];
  logic [15:0]           fifo_d [BUF_PARCELS];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [CW-1:0]         count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  out_valid_q, out_valid_d, out_comp_q, out_comp_d, out_ill_q, out_ill_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;

  logic                  accept, is32, has1, has2, issue;
  logic [1:0]            in_cnt, pop;
  logic [15:0]           in_p0, p0, p1;
  logic [32:0]           exp_c;
  logic                  unused_flush_pc_lsb;

  assign unused_flush_pc_lsb = flush_pc_i[0];

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW - 1){1'b0}}, n};
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

`ifdef RV2T_COMPRESSED_EXPAND_EN
  // Returns {illegal, instr}; illegal encodings expand to all-zero.
  function automatic logic [32:0] rvc_expand(input logic [15:0] c);
    logic [31:0] i;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rsp;
    rd  = c[11:7];
    rs2 = c[6:2];
    rdp = {2'b01, c[4:2]};
    rsp = {2'b01, c[9:7]};
    i   = '0;
    ill = 1'b0;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        i   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
        ill = (c[12:5] == 8'd0);
      end
      5'b00_010: i = {5'd0, c[5], c[12:10], c[6], 2'b00, rsp, 3'b010, rdp, 7'b0000011};
      5'b00_110: i = {5'd0, c[5], c[12], rdp, rsp, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000: i = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'b0010011};
      5'b01_001, 5'b01_101: i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                                 c[12], {8{c[12]}}, 4'b0000, ~c[15], 7'b1101111};
      5'b01_010: i = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
      5'b01_011: begin
        ill = ({c[12], c[6:2]} == 6'd0);
        if (rd == 5'd2) begin
          i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
        end else begin
          i = {{14{c[12]}}, c[12], c[6:2], rd, 7'b0110111};
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            i   = {7'b0000000, c[6:2], rsp, 3'b101, rsp, 7'b0010011};
            ill = c[12];
          end
          2'b01: begin
            i   = {7'b0100000, c[6:2], rsp, 3'b101, rsp, 7'b0010011};
            ill = c[12];
          end
          2'b10: i = {{6{c[12]}}, c[12], c[6:2], rsp, 3'b111, rsp, 7'b0010011};
          default: begin
            ill = c[12];
            case (c[6:5])
              2'b00:   i = {7'b0100000, rdp, rsp, 3'b000, rsp, 7'b0110011};
              2'b01:   i = {7'b0000000, rdp, rsp, 3'b100, rsp, 7'b0110011};
              2'b10:   i = {7'b0000000, rdp, rsp, 3'b110, rsp, 7'b0110011};
              default: i = {7'b0000000, rdp, rsp, 3'b111, rsp, 7'b0110011};
            endcase
          end
        endcase
      end
      5'b01_110, 5'b01_111: i = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rsp, 2'b00, c[13],
                                 c[11:10], c[4:3], c[12], 7'b1100011};
      5'b10_000: begin
        i   = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
        ill = c[12];
      end
      5'b10_010: begin
        i   = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
        ill = (rd == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            i   = {12'd0, rd, 3'b000, 5'd0, 7'b1100111};
            ill = (rd == 5'd0);
          end else begin
            i = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
          end
        end else if (rd == 5'd0 && rs2 == 5'd0) begin
          i = 32'h0010_0073;
        end else if (rs2 == 5'd0) begin
          i = {12'd0, rd, 3'b000, 5'd1, 7'b1100111};
        end else begin
          i = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
        end
      end
      5'b10_110: i = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
      default:   ill = 1'b1;
    endcase
    if (ill) i = '0;
    return {ill, i};
  endfunction
`endif

  assign fetch_ready_o = !flush_i && (count_q <= MAX_FILL);

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_comp_d  = out_comp_q;
    out_ill_d   = out_ill_q;

    accept    = fetch_valid_i && fetch_ready_o;
    in_p0     = (state_q == ST_SKIP_LO) ? fetch_data_i[31:16] : fetch_data_i[15:0];
    in_cnt    = !accept ? 2'd0 : (state_q == ST_SKIP_LO) ? 2'd1 : 2'd2;
    rd_ptr_nx = ptr_add(rd_ptr_q, 2'd1);

    // Head view spans buffered parcels followed by the word being accepted this cycle.
    p0   = (count_q != '0) ? fifo_q[rd_ptr_q] : in_p0;
    p1   = (count_q >= CW'(2)) ? fifo_q[rd_ptr_nx] :
           (count_q == CW'(1)) ? in_p0 : fetch_data_i[31:16];
    has1 = (count_q != '0) || (in_cnt != 2'd0);
    has2 = (count_q >= CW'(2)) || ((count_q == CW'(1)) && (in_cnt != 2'd0)) || (in_cnt == 2'd2);
    is32 = (p0[1:0] == 2'b11);
    issue = !flush_i && (!out_valid_q || out_ready_i) && (is32 ? has2 : has1);
    pop   = !issue ? 2'd0 : is32 ? 2'd2 : 2'd1;

`ifdef RV2T_COMPRESSED_EXPAND_EN
    exp_c = rvc_expand(p0);
`else
    exp_c = {1'b1, 32'h0};
`endif

    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      state_d     = flush_pc_i[1] ? ST_SKIP_LO : ST_ALIGNED;
      pc_d        = {flush_pc_i[ADDR_WIDTH-1:1], 1'b0};
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        fifo_d[wr_ptr_q] = in_p0;
        if (state_q == ST_ALIGNED) fifo_d[ptr_add(wr_ptr_q, 2'd1)] = fetch_data_i[31:16];
        state_d = ST_ALIGNED;
      end
      wr_ptr_d = ptr_add(wr_ptr_q, in_cnt);
      rd_ptr_d = ptr_add(rd_ptr_q, pop);
      count_d  = count_q + {{(CW - 2){1'b0}}, in_cnt} - {{(CW - 2){1'b0}}, pop};
      if (issue) begin
        out_valid_d = 1'b1;
        out_instr_d = is32 ? {p1, p0} : exp_c[31:0];
        out_pc_d    = pc_q;
        out_comp_d  = !is32;
        out_ill_d   = !is32 && exp_c[32];
        pc_d        = pc_q + {{(ADDR_WIDTH - 3){1'b0}}, is32, !is32, 1'b0};
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < BUF_PARCELS; k++) fifo_q[k] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_ALIGNED;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_comp_q  <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_comp_q  <= out_comp_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid_o         = out_valid_q;
  assign out_instr_o         = out_instr_q;
  assign out_pc_o            = out_pc_q;
  assign out_is_compressed_o = out_comp_q;
  assign out_illegal_o       = out_ill_q;

endmodule
